// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between N producers, the round-robin arbiter and one FIFO write port.
// The optional req_lock vector exists only when FIFO_ARB_LOCK_EN is defined.
interface fifo_wr_arbiter_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]       req_valid;
  logic [N*WIDTH-1:0] req_data;
  logic [N-1:0]       req_ready;
  logic               fifo_full;
  logic               fifo_almost_full;
  logic               fifo_wr_en;
  logic [WIDTH-1:0]   fifo_wr_data;
  logic [IDW-1:0]     fifo_wr_src;
  logic               busy;
`ifdef FIFO_ARB_LOCK_EN
  logic [N-1:0]       req_lock;

  modport master (
    output req_valid, req_data, req_lock, fifo_full, fifo_almost_full,
    input  req_ready, fifo_wr_en, fifo_wr_data, fifo_wr_src, busy
  );
  modport slave (
    input  req_valid, req_data, req_lock, fifo_full, fifo_almost_full,
    output req_ready, fifo_wr_en, fifo_wr_data, fifo_wr_src, busy
  );
`else
  modport master (
    output req_valid, req_data, fifo_full, fifo_almost_full,
    input  req_ready, fifo_wr_en, fifo_wr_data, fifo_wr_src, busy
  );
  modport slave (
    input  req_valid, req_data, fifo_full, fifo_almost_full,
    output req_ready, fifo_wr_en, fifo_wr_data, fifo_wr_src, busy
  );
`endif
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter for one FIFO write port; 1-cycle registered write, grants held off by full/almost-full.
// Optional FIFO_ARB_LOCK_EN: a locked beat keeps rr_ptr on its winner so the source can burst.
module fifo_wr_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  fifo_wr_arbiter_if.slave  i_bus
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic [IDW-1:0]   r_rr_ptr;
  logic             r_wr_en;
  logic [WIDTH-1:0] r_wr_data;
  logic [IDW-1:0]   r_wr_src;

  logic             w_space_ok;
  logic             w_found;
  logic [IDW-1:0]   w_win;
  logic [IDW-1:0]   w_win_nxt;
  logic [N-1:0]     w_ready;
  logic             w_accept;

  // Reads are invisible here, so a write in flight counts against almost-full.
  assign w_space_ok = !i_bus.fifo_full && !(i_bus.fifo_almost_full && r_wr_en);

  always_comb begin : p_arb
    int idx;
    w_found = 1'b0;
    w_win   = '0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!w_found && i_bus.req_valid[idx]) begin
        w_found = 1'b1;
        w_win   = IDW'(idx);
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (i_rst_n && w_found && w_space_ok) w_ready[w_win] = 1'b1;
  end

  assign w_accept  = |(w_ready & i_bus.req_valid);
  assign w_win_nxt = (int'(w_win) == N - 1) ? '0 : w_win + 1'b1;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rr_ptr  <= '0;
      r_wr_en   <= 1'b0;
      r_wr_data <= '0;
      r_wr_src  <= '0;
    end else if (w_accept) begin
      r_wr_en   <= 1'b1;
      r_wr_data <= i_bus.req_data[int'(w_win)*WIDTH +: WIDTH];
      r_wr_src  <= w_win;
`ifdef FIFO_ARB_LOCK_EN
      r_rr_ptr  <= i_bus.req_lock[w_win] ? w_win : w_win_nxt;
`else
      r_rr_ptr  <= w_win_nxt;
`endif
    end else begin
      r_wr_en   <= 1'b0;
    end
  end

  assign i_bus.req_ready    = w_ready;
  assign i_bus.fifo_wr_en   = r_wr_en;
  assign i_bus.fifo_wr_data = r_wr_data;
  assign i_bus.fifo_wr_src  = r_wr_src;
  assign i_bus.busy         = (|i_bus.req_valid) || r_wr_en;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed scenarios then random traffic, each cycle compared against a queue-free round-robin reference model.
module tb_fifo_wr_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.N(N), .WIDTH(W)) bus ();
  fifo_wr_arbiter #(.N(N), .WIDTH(W)) dut (.i_clk(clk), .i_rst_n(rst_n), .i_bus(bus));

  int n_pass = 0;
  int n_total = 0;

  logic [N-1:0] v;
  logic [W-1:0] d [N];
  logic [N-1:0] lk;
  logic         full, af;

  int           m_ptr;
  logic         m_wr_en;
  logic [W-1:0] m_data;
  int           m_src;

  logic [N-1:0] obs_ready;
  logic         obs_en;
  logic [W-1:0] obs_data;
  logic [31:0]  obs_src;
  logic [N-1:0] acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int winner(input logic [N-1:0] vv, input int ptr);
    for (int k = 0; k < N; k++)
      if (vv[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic apply();
    bus.req_valid        = v;
    bus.fifo_full        = full;
    bus.fifo_almost_full = af;
    for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = d[i];
`ifdef FIFO_ARB_LOCK_EN
    bus.req_lock = lk;
`endif
  endtask

  task automatic cycle();
    logic [N-1:0] er;
    int  w;
    bit  sp;
    apply();
    @(negedge clk);
    er = '0;
    sp = !full && !(af && m_wr_en);
    w  = winner(v, m_ptr);
    if (rst_n && sp && w >= 0) er[w] = 1'b1;
    obs_ready = bus.req_ready;
    obs_en    = bus.fifo_wr_en;
    obs_data  = bus.fifo_wr_data;
    obs_src   = 32'(bus.fifo_wr_src);
    chk("req_ready", 32'(obs_ready), 32'(er));
    chk("wr_en", 32'(obs_en), 32'(m_wr_en));
    chk("wr_data", 32'(obs_data), 32'(m_data));
    chk("wr_src", obs_src, 32'(m_src));
    chk("busy", 32'(bus.busy), 32'((|v) || m_wr_en));
    @(posedge clk);
    acc = er & v;
    if (!rst_n) begin
      m_ptr = 0; m_wr_en = 1'b0; m_data = '0; m_src = 0;
    end else if (er != '0) begin
      m_wr_en = 1'b1;
      m_data  = d[w];
      m_src   = w;
      m_ptr   = (w + 1) % N;
`ifdef FIFO_ARB_LOCK_EN
      if (lk[w]) m_ptr = w;
`endif
    end else begin
      m_wr_en = 1'b0;
    end
    #1;
  endtask

  initial begin
    v = '0; lk = '0; full = 1'b0; af = 1'b0; acc = '0;
    for (int i = 0; i < N; i++) d[i] = 8'(8'h10 + i);
    bus.req_valid = '0; bus.req_data = '0; bus.fifo_full = 1'b0; bus.fifo_almost_full = 1'b0;
`ifdef FIFO_ARB_LOCK_EN
    bus.req_lock = '0;
`endif
    // Unchecked first edge clears the X state on both sides.
    rst_n = 1'b0; v = '1;
    apply();
    @(posedge clk);
    m_ptr = 0; m_wr_en = 1'b0; m_data = '0; m_src = 0;
    #1;

    // Reset held with every requester valid
    cycle(); chk("rst_ready", 32'(obs_ready), 32'h0);
    cycle(); chk("rst_ready2", 32'(obs_ready), 32'h0);
    rst_n = 1'b1;
    cycle();
    chk("rel_ready", 32'(obs_ready), 32'h1);
    chk("rel_en", 32'(obs_en), 32'h0);
    chk("rel_src", obs_src, 32'h0);

    // Fairness: all valid, sources rotate 0,1,2,3,0,...
    for (int c = 0; c < 8; c++) begin
      cycle();
      chk("fair_src", obs_src, 32'(c % N));
      chk("fair_en", 32'(obs_en), 32'h1);
      chk("fair_data", 32'(obs_data), 32'(8'h10 + (c % N)));
    end

    // Skip/wrap: park pointer at 2 by granting req 1, then only 1 and 3 compete
    v = 4'b0010; d[1] = 8'hA1; d[3] = 8'hC3;
    cycle(); chk("park_ready", 32'(obs_ready), 32'h2);
    v = 4'b1010;
    cycle(); chk("wrap_g3", 32'(obs_ready), 32'h8);
    cycle(); chk("wrap_g1", 32'(obs_ready), 32'h2);
    chk("wrap_d3", 32'(obs_data), 32'hC3);
    cycle(); chk("wrap_g3b", 32'(obs_ready), 32'h8);
    chk("wrap_d1", 32'(obs_data), 32'hA1);
    cycle(); chk("wrap_d3b", 32'(obs_data), 32'hC3);

    // Backpressure: almost-full with a write in flight blocks; then full for 5 cycles
    v = '1; af = 1'b1;
    cycle(); chk("af_block", 32'(obs_ready), 32'h0);
    cycle(); chk("af_idle_ok", 32'(|obs_ready), 32'h1);
    af = 1'b0; full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk("full_ready", 32'(obs_ready), 32'h0);
      if (c > 0) chk("full_no_wr", 32'(obs_en), 32'h0);
    end
    full = 1'b0;
    cycle(); chk("resume", 32'(|obs_ready), 32'h1);
    v = '0;
    cycle();

    // Mid-stream reset drops the in-flight 0x55 write
    v = 4'b0001; d[0] = 8'h55;
    cycle(); chk("pre_acc", 32'(obs_ready), 32'h1);
    v = '0; rst_n = 1'b0;
    cycle(); chk("inflight_55", 32'(obs_data), 32'h55);
    rst_n = 1'b1; v = '1;
    cycle();
    chk("mrst_en", 32'(obs_en), 32'h0);
    chk("mrst_ptr0", 32'(obs_ready), 32'h1);

`ifdef FIFO_ARB_LOCK_EN
    // Lock: req 2 bursts three beats, releasing on the third, then req 0
    v = 4'b0101; d[0] = 8'h0A; d[2] = 8'h2B; lk = 4'b0100;
    cycle(); chk("lk_g1", 32'(obs_ready), 32'h4);
    cycle(); chk("lk_g2", 32'(obs_ready), 32'h4); chk("lk_s1", obs_src, 32'h2);
    lk = 4'b0000;
    cycle(); chk("lk_g3", 32'(obs_ready), 32'h4); chk("lk_s2", obs_src, 32'h2);
    cycle(); chk("lk_g4", 32'(obs_ready), 32'h1); chk("lk_s3", obs_src, 32'h2);
    cycle(); chk("lk_s4", obs_src, 32'h0);
`endif

    // Random traffic; an unaccepted request keeps valid and data stable
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] || acc[i]) begin
          v[i] = ($urandom_range(0, 2) != 0);
          d[i] = 8'($urandom);
          lk[i] = ($urandom_range(0, 3) == 0);
        end
      end
      full = ($urandom_range(0, 9) == 0);
      af   = ($urandom_range(0, 4) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
